writeback_arbiter: RTL
======================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queued write entries (power of two, 2..8).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, rising-edge.
REQ-003 The block SHALL have port Reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port MemValid, input, 1 bit: load-result write request.
REQ-005 The block SHALL have port MemRd, input, 5 bits: load destination register.
REQ-006 The block SHALL have port MemData, input, 64 bits: load write data.
REQ-007 The block SHALL have port MemReady, output, 1 bit: load request accepted this cycle if MemValid.
REQ-008 The block SHALL have port AluValid, input, 1 bit: ALU-result write request.
REQ-009 The block SHALL have port AluRd, input, 5 bits: ALU destination register.
REQ-010 The block SHALL have port AluData, input, 64 bits: ALU write data.
REQ-011 The block SHALL have port AluReady, output, 1 bit: ALU request accepted this cycle if AluValid.
REQ-012 The block SHALL have port Stall, input, 1 bit: register-file write port unavailable; no dequeue.
REQ-013 The block SHALL have port RW, output, 5 bits: register-file write address, registered.
REQ-014 The block SHALL have port BusW, output, 64 bits: register-file write data, registered.
REQ-015 The block SHALL have port RegWr, output, 1 bit: register-file write enable, registered.
REQ-016 The block SHALL have port Pending, output, 32 bits: bit r = write to register r outstanding.
REQ-017 The block SHALL have port Count, output, 4 bits: current queue occupancy.

Function
REQ-018 Queue SHALL be a FIFO of DEPTH entries {rd[4:0], data[63:0]}; at most one enqueue and one dequeue per edge.
REQ-019 MemReady SHALL be (Count < DEPTH); AluReady SHALL be (Count < DEPTH) and not MemValid; load wins simultaneous requests.
REQ-020 Full queue SHALL deassert both readys even when a dequeue occurs in the same cycle (no same-cycle pass-through).
REQ-021 An accepted request with rd = 31 (zero register) SHALL be consumed without enqueue: Count unchanged, no RegWr ever issued.
REQ-022 Accepted request with rd != 31 SHALL be written to the tail at the accepting edge.
REQ-023 At each edge with Stall = 0 and Count > 0, the head SHALL be popped into RW/BusW and RegWr SHALL be 1 for the following cycle.
REQ-024 At each edge with Stall = 1 or Count = 0, RegWr SHALL become 0; RW/BusW SHALL hold their last values.
REQ-025 Minimum latency: request accepted at edge k SHALL appear as RegWr = 1 in the cycle after edge k+1.
REQ-026 Writes SHALL issue in acceptance order; duplicate rd values SHALL each issue, none merged or dropped.
REQ-027 Count SHALL be +1 on enqueue only, -1 on dequeue only, unchanged on both or neither; pointers wrap modulo DEPTH.
REQ-028 Pending[r] SHALL be 1 iff a valid queue entry or the current RegWr = 1 output holds rd = r; Pending[31] SHALL always be 0.
REQ-029 Pending, MemReady, AluReady SHALL be combinational from registered state and current inputs only.

Reset
REQ-030 Reset_L low SHALL immediately clear Count, pointers, RegWr, RW, BusW and Pending to 0, independent of CLK.
REQ-031 While Reset_L is low, MemReady and AluReady SHALL be 0 and no request SHALL be accepted.
REQ-032 Entries queued at reset assertion SHALL be discarded; no RegWr SHALL occur for them after release.
REQ-033 First acceptance SHALL be possible at the first rising edge with Reset_L high.

Verification
REQ-034 ALU rd=5, data 0x1234 at edge k, Stall=0 -> RegWr=1, RW=5, BusW=0x1234 for exactly one cycle after edge k+1; Pending[5]=1 from edge k until that cycle ends.
REQ-035 MemValid rd=2 and AluValid rd=3 same cycle -> AluReady=0, load accepted; ALU accepted next edge; writes issue 2 then 3.
REQ-036 Stall=1, five ALU requests back-to-back -> four accepted, Count=4, AluReady=MemReady=0; Stall=0 -> four writes on consecutive cycles in order.
REQ-037 ALU rd=31, data 0xFFFF -> accepted, Count stays 0, RegWr stays 0, Pending stays 0.
REQ-038 Same rd=7, data 0xA then 0xB -> two writes in order (0xA, 0xB); Pending[7] clears only after the 0xB cycle.
REQ-039 Stall=1, three entries queued, Reset_L pulsed low mid-cycle -> Count, RegWr, Pending=0 immediately; after release with Stall=0 no RegWr occurs.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// Bundle of request, handshake and register-file write signals for writeback_arbiter.
// The master side drives requests and Stall. The slave side is the arbiter.
interface writeback_arbiter_if;
   logic        MemValid;
   logic [4:0]  MemRd;
   logic [63:0] MemData;
   logic        MemReady;
   logic        AluValid;
   logic [4:0]  AluRd;
   logic [63:0] AluData;
   logic        AluReady;
   logic        Stall;
   logic [4:0]  RW;
   logic [63:0] BusW;
   logic        RegWr;
   logic [31:0] Pending;
   logic [3:0]  Count;

   modport master (
      output MemValid, MemRd, MemData, AluValid, AluRd, AluData, Stall,
      input  MemReady, AluReady, RW, BusW, RegWr, Pending, Count
   );

   modport slave (
      input  MemValid, MemRd, MemData, AluValid, AluRd, AluData, Stall,
      output MemReady, AluReady, RW, BusW, RegWr, Pending, Count
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Arbitrates load and ALU results into an in-order write queue that drains to one register-file port.
// Loads win ties. Writes to register 31 are accepted and then dropped.
module writeback_arbiter #(
   parameter int DEPTH = 4
) (
   input logic                CLK,
   input logic                Reset_L,
   writeback_arbiter_if.slave bus
);
   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);
   localparam logic [4:0] ZERO_REG  = 5'd31;

   typedef logic [AW-1:0] ptr_t;

   logic [4:0]  queue_rd   [DEPTH];
   logic [63:0] queue_data [DEPTH];

   ptr_t        head_reg;
   ptr_t        tail_reg;
   logic [3:0]  count_reg;
   logic [4:0]  rw_reg;
   logic [63:0] busw_reg;
   logic        regwr_reg;

   logic             not_full;
   logic             mem_acc;
   logic             alu_acc;
   logic             enq;
   logic             deq;
   logic [4:0]       acc_rd;
   logic [63:0]      acc_data;
   logic [DEPTH-1:0] entry_valid;
   logic [31:0]      pending;

   // Readiness ignores any dequeue in the same cycle, so a full queue never passes a request through.
   assign not_full = Reset_L && (count_reg < DEPTH_CNT);
   assign mem_acc  = bus.MemValid && not_full;
   assign alu_acc  = bus.AluValid && not_full && !bus.MemValid;
   assign acc_rd   = mem_acc ? bus.MemRd : bus.AluRd;
   assign acc_data = mem_acc ? bus.MemData : bus.AluData;
   assign enq      = (mem_acc || alu_acc) && (acc_rd != ZERO_REG);
   assign deq      = !bus.Stall && (count_reg != 4'd0);

   assign bus.MemReady = not_full;
   assign bus.AluReady = not_full && !bus.MemValid;
   assign bus.RW       = rw_reg;
   assign bus.BusW     = busw_reg;
   assign bus.RegWr    = regwr_reg;
   assign bus.Count    = count_reg;
   assign bus.Pending  = pending;

   always_ff @(posedge CLK) begin
      if (enq) begin
         queue_rd[tail_reg]   <= acc_rd;
         queue_data[tail_reg] <= acc_data;
      end
   end

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         rw_reg    <= '0;
         busw_reg  <= '0;
         regwr_reg <= 1'b0;
      end else begin
         if (enq) tail_reg <= tail_reg + 1'b1;
         if (deq) head_reg <= head_reg + 1'b1;
         case ({enq, deq})
            2'b10:   count_reg <= count_reg + 4'd1;
            2'b01:   count_reg <= count_reg - 4'd1;
            default: count_reg <= count_reg;
         endcase
         regwr_reg <= deq;
         if (deq) begin
            rw_reg   <= queue_rd[head_reg];
            busw_reg <= queue_data[head_reg];
         end
      end
   end

   // A slot is live when its distance from the head is below the occupancy.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_valid
         ptr_t offset;
         assign offset          = ptr_t'(gi) - head_reg;
         assign entry_valid[gi] = {{(4-AW){1'b0}}, offset} < count_reg;
      end
   endgenerate

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i]) pending[queue_rd[i]] = 1'b1;
      end
      if (regwr_reg) pending[rw_reg] = 1'b1;
      pending[31] = 1'b0;
   end
endmodule
